// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the ROM address and registers the
// returned word into a single fetch slot with branch squash, stall and halt.
module inst_fetch #(
  parameter int unsigned     PC_W       = 8,
  parameter int unsigned     INST_W     = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic              BranchRel,
  input  logic [PC_W-1:0]   BranchTarget,
  input  logic              Halt,
  output logic [PC_W-1:0]   Address,
  input  logic [INST_W-1:0] InstrIn,
  output logic [INST_W-1:0] Instr,
  output logic [PC_W-1:0]   InstrPC,
  output logic              InstrValid,
  output logic              Done
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]     instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    done_d     = done_q;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (Start) begin
          state_d = StRun;
          pc_d    = START_ADDR;
        end
      end
      StRun: begin
        // Stall freezes everything; branch/halt are not sampled while stalled.
        if (!Stall) begin
          if (Halt && valid_q) begin
            state_d = StHalted;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (BranchEn && valid_q) begin
            // Same-width add wraps mod 2^PC_W, which equals the sign-extended sum.
            valid_d = 1'b0;
            pc_d    = BranchRel ? (instr_pc_q + BranchTarget) : BranchTarget;
          end else begin
            instr_d    = InstrIn;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + PcOne;
          end
        end
      end
      StHalted: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        if (Start) begin
          state_d = StRun;
          pc_d    = START_ADDR;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StIdle;
      pc_q       <= START_ADDR;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign Address    = pc_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign InstrValid = valid_q;
  assign Done       = done_q;

endmodule
